// File: rtl/manchester_tx.sv
// manchester_tx: serialises a DATA_W-bit word onto a single line using one of
// four line codes (IEEE Manchester, Thomas Manchester, differential
// Manchester, NRZ). One clk period is one half-bit on the line.
//
// state | meaning
// IDLE  | line parked at IDLE_LVL, ready for a word
// SEND  | shifting out a word, half selects first/second half of current bit
module manchester_tx #(
  parameter int DATA_W    = 8,
  parameter int MSB_FIRST = 1,
  parameter int IDLE_LVL  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              man_out,
  output logic              busy,
  output logic              word_done
);

  localparam int   CNT_W    = $clog2(DATA_W);
  localparam logic IDLE_BIT = (IDLE_LVL != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1
  } state_t;

  state_t            state;
  logic              half;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic [1:0]        mode_q;

  logic              accept;
  logic              in_bit;
  logic              cur_bit;
  logic              next_bit;
  logic              last_bit;
  logic [DATA_W-1:0] shreg_shifted;

  // First-half level of a bit; prev is the line level just before the bit.
  function automatic logic first_level(input logic [1:0] m, input logic b,
                                       input logic prev);
    logic lvl;
    case (m)
      2'b00:   lvl = ~b;
      2'b01:   lvl = b;
      2'b10:   lvl = b ? prev : ~prev;
      default: lvl = b;
    endcase
    return lvl;
  endfunction

  // Second-half level of a bit; first is the level driven in its first half.
  function automatic logic second_level(input logic [1:0] m, input logic b,
                                        input logic first);
    logic lvl;
    case (m)
      2'b00:   lvl = b;
      2'b01:   lvl = ~b;
      2'b10:   lvl = ~first;
      default: lvl = b;
    endcase
    return lvl;
  endfunction

  // Bit selection and shift direction depend only on MSB_FIRST.
  always_comb begin
    accept   = in_valid & in_ready;
    last_bit = (cnt == '0);
    if (MSB_FIRST != 0) begin
      in_bit        = in_data[DATA_W-1];
      cur_bit       = shreg[DATA_W-1];
      next_bit      = shreg[DATA_W-2];
      shreg_shifted = {shreg[DATA_W-2:0], 1'b0};
    end else begin
      in_bit        = in_data[0];
      cur_bit       = shreg[0];
      next_bit      = shreg[1];
      shreg_shifted = {1'b0, shreg[DATA_W-1:1]};
    end
  end

  // Transmit FSM with registered line and handshake outputs. The bit counter
  // counts down from DATA_W-1; zero marks the last bit of the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      half      <= 1'b0;
      cnt       <= '0;
      shreg     <= '0;
      mode_q    <= 2'b00;
      man_out   <= IDLE_BIT;
      busy      <= 1'b0;
      word_done <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      word_done <= 1'b0;
      case (state)
        IDLE: begin
          half <= 1'b0;
          if (accept) begin
            // Zero latency: the first half of the first bit goes out now.
            state    <= SEND;
            cnt      <= CNT_W'(DATA_W - 1);
            shreg    <= in_data;
            mode_q   <= mode;
            man_out  <= first_level(mode, in_bit, man_out);
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end else begin
            man_out  <= IDLE_BIT;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end
        end
        SEND: begin
          if (!half) begin
            man_out  <= second_level(mode_q, cur_bit, man_out);
            half     <= 1'b1;
            in_ready <= last_bit;
          end else if (!last_bit) begin
            shreg    <= shreg_shifted;
            cnt      <= cnt - CNT_W'(1);
            half     <= 1'b0;
            man_out  <= first_level(mode_q, next_bit, man_out);
            in_ready <= 1'b0;
          end else begin
            word_done <= 1'b1;
            half      <= 1'b0;
            if (accept) begin
              // Back-to-back: previous level for differential mode is the
              // second half just driven, i.e. the current man_out.
              cnt      <= CNT_W'(DATA_W - 1);
              shreg    <= in_data;
              mode_q   <= mode;
              man_out  <= first_level(mode, in_bit, man_out);
              busy     <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              state    <= IDLE;
              cnt      <= '0;
              man_out  <= IDLE_BIT;
              busy     <= 1'b0;
              in_ready <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          half     <= 1'b0;
          cnt      <= '0;
          man_out  <= IDLE_BIT;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_manchester_tx.sv
// Bench for manchester_tx: queue-based line model checked every cycle, plus
// literal half-bit sequences for the reference words.
module tb_manchester_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, man_out, busy, word_done;

  logic [1:0] lsb_mode = 2'b00;
  logic [7:0] lsb_data = 8'h00;
  logic       lsb_valid = 1'b0;
  logic       lsb_ready, lsb_out, lsb_busy, lsb_done;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  manchester_tx #(.DATA_W(8), .MSB_FIRST(1), .IDLE_LVL(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .man_out(man_out),
    .busy(busy), .word_done(word_done)
  );

  manchester_tx #(.DATA_W(8), .MSB_FIRST(0), .IDLE_LVL(1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .mode(lsb_mode), .in_data(lsb_data),
    .in_valid(lsb_valid), .in_ready(lsb_ready), .man_out(lsb_out),
    .busy(lsb_busy), .word_done(lsb_done)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: a queue of line levels still to be shown for the word in flight.
  bit exp_q[$];
  logic exp_man = 1'b0;
  bit exp_busy = 1'b0;
  bit exp_ready = 1'b0;
  bit exp_wd = 1'b0;

  function automatic void push_word(input logic [7:0] d, input logic [1:0] m, input logic prev);
    logic lvl = prev;
    logic b, h1, h2;
    for (int i = 7; i >= 0; i--) begin
      b = d[i];
      case (m)
        2'b00: begin h1 = !b; h2 = b; end
        2'b01: begin h1 = b; h2 = !b; end
        2'b10: begin h1 = b ? lvl : !lvl; h2 = !h1; end
        default: begin h1 = b; h2 = b; end
      endcase
      exp_q.push_back(h1);
      exp_q.push_back(h2);
      lvl = h2;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_man = 1'b0;
      exp_busy = 1'b0;
      exp_ready = 1'b0;
      exp_wd = 1'b0;
    end else begin
      exp_wd = exp_busy && (exp_q.size() == 0);
      if (in_valid && exp_ready) push_word(in_data, mode, exp_man);
      if (exp_q.size() > 0) begin
        exp_man = exp_q.pop_front();
        exp_busy = 1'b1;
      end else begin
        exp_man = 1'b0;
        exp_busy = 1'b0;
      end
      exp_ready = !exp_busy || (exp_q.size() == 0);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("man_out", {31'd0, man_out}, {31'd0, exp_man});
      check("busy", {31'd0, busy}, {31'd0, exp_busy});
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      check("word_done", {31'd0, word_done}, {31'd0, exp_wd});
    end
  end

  task automatic wait_ready();
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  // Single word from idle; inputs are scrambled right after accept.
  task automatic run_word(input logic [7:0] d, input logic [1:0] m,
                          input logic [15:0] exp_seq, input string nm);
    logic [15:0] rec = '0;
    @(negedge clk);
    wait_ready();
    in_data = d;
    mode = m;
    in_valid = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 1) begin
        in_valid = 1'b0;
        in_data = ~d;
        mode = ~m;
      end
      if (k <= 16) rec = {rec[14:0], man_out};
      if (k == 16) check({nm, "_wd_early"}, {31'd0, word_done}, 32'd0);
      if (k == 17) check({nm, "_wd"}, {31'd0, word_done}, 32'd1);
    end
    check(nm, {16'd0, rec}, {16'd0, exp_seq});
  endtask

  task automatic run_b2b(input logic [7:0] d1, input logic [7:0] d2, input logic [1:0] m,
                         output logic [31:0] r_line, output logic [31:0] r_busy,
                         output logic [31:0] r_ready, output logic [31:0] r_wd,
                         output logic wd_last);
    r_line = '0; r_busy = '0; r_ready = '0; r_wd = '0; wd_last = 1'b0;
    @(negedge clk);
    wait_ready();
    in_data = d1;
    mode = m;
    in_valid = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k <= 32) begin
        r_line = {r_line[30:0], man_out};
        r_busy = {r_busy[30:0], busy};
        r_ready = {r_ready[30:0], in_ready};
        r_wd = {r_wd[30:0], word_done};
      end
      if (k == 1) in_data = d2;
      if (k == 17) in_valid = 1'b0;
      if (k == 33) wd_last = word_done;
    end
  endtask

  initial begin
    logic [31:0] r_line, r_busy, r_ready, r_wd;
    logic wd_last;
    logic [15:0] lrec;

    repeat (3) @(negedge clk);
    check("rst_man_out", {31'd0, man_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_word_done", {31'd0, word_done}, 32'd0);
    check("rst_lsb_idle_lvl", {31'd0, lsb_out}, 32'd1);
    chk_en = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'd0, in_ready}, 32'd1);

    run_word(8'hA5, 2'b00, 16'h6699, "ieee_a5");
    run_word(8'hA5, 2'b01, 16'h9966, "thomas_a5");
    run_word(8'hA5, 2'b11, 16'hCC33, "nrz_a5");
    run_word(8'h00, 2'b10, 16'hAAAA, "diff_00");
    run_word(8'hFF, 2'b10, 16'h6666, "diff_ff");

    run_b2b(8'hA5, 8'h3C, 2'b00, r_line, r_busy, r_ready, r_wd, wd_last);
    check("b2b_line", r_line, 32'h6699A55A);
    check("b2b_busy", r_busy, 32'hFFFFFFFF);
    check("b2b_ready", r_ready, 32'h00010001);
    check("b2b_wd", r_wd, 32'h00008000);
    check("b2b_wd_last", {31'd0, wd_last}, 32'd1);

    // Differential back-to-back: second word starts from the last level.
    run_b2b(8'h0F, 8'hF0, 2'b10, r_line, r_busy, r_ready, r_wd, wd_last);
    run_b2b(8'h5A, 8'h81, 2'b11, r_line, r_busy, r_ready, r_wd, wd_last);

    // Reset in cycle 5 of a word.
    @(negedge clk);
    wait_ready();
    in_data = 8'hA5;
    mode = 2'b00;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_man_out", {31'd0, man_out}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_word_done", {31'd0, word_done}, 32'd0);
    #1 rst_n = 1'b1;
    run_word(8'hA5, 2'b00, 16'h6699, "after_rst_a5");

    // LSB-first instance, idle level high.
    @(negedge clk);
    check("lsb_idle", {31'd0, lsb_out}, 32'd1);
    check("lsb_ready", {31'd0, lsb_ready}, 32'd1);
    lsb_data = 8'h01;
    lsb_mode = 2'b00;
    lsb_valid = 1'b1;
    lrec = '0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 1) lsb_valid = 1'b0;
      if (k <= 16) lrec = {lrec[14:0], lsb_out};
      if (k == 17) begin
        check("lsb_wd", {31'd0, lsb_done}, 32'd1);
        check("lsb_back_idle", {31'd0, lsb_out}, 32'd1);
      end
    end
    check("lsb_01", {16'd0, lrec}, 32'h00006AAA);

    repeat (4) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
